// File: rtl/mac_pkg.sv
// Shared types and helpers for the mac_accum dot-product accumulator.
package mac_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } mac_state_t;

    localparam int PROD_W = 6;

    // Sign-extends a product to 32 bits; callers size-cast down to their accumulator width.
    function automatic logic [31:0] sext_prod(input logic [PROD_W-1:0] p);
        return {{(32-PROD_W){p[PROD_W-1]}}, p};
    endfunction

endpackage

// File: rtl/mac_add_sat.sv
// Combinational W-bit two's-complement adder with signed-overflow detect.
// Optional saturation on overflow when MAC_ACCUM_SAT_EN is defined.
module mac_add_sat #(
    parameter int W = 9
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         ovf
);

    logic [W-1:0] raw;

    assign raw = a + b;
    // Equal-sign operands producing a result of the other sign.
    assign ovf = (a[W-1] == b[W-1]) && (raw[W-1] != a[W-1]);

`ifdef MAC_ACCUM_SAT_EN
    always_comb begin
        sum = raw;
        if (ovf) begin
            sum = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
    end
`else
    assign sum = raw;
`endif

endmodule

// File: rtl/mac_accum.sv
// Accumulates N_TERMS signed products per result with valid/ready on both sides.
// Build option MAC_ACCUM_SAT_EN selects saturating instead of wrapping adds.
module mac_accum
    import mac_pkg::*;
#(
    parameter int N_TERMS = 8,
    parameter int ACC_W   = PROD_W + $clog2(N_TERMS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PROD_W-1:0] prod_i,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    output logic [ACC_W-1:0]  sum_o,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              ovf_o
);

    localparam int CNT_W = $clog2(N_TERMS + 1);

    mac_state_t       state_reg, state_next;
    logic [ACC_W-1:0] acc_reg, acc_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [ACC_W-1:0] sum_reg, sum_next;
    logic             ovf_reg, ovf_next;
    logic             rdy_reg;

    logic [ACC_W-1:0] add_a;
    logic [ACC_W-1:0] add_b;
    logic [ACC_W-1:0] add_sum;
    logic             add_ovf;
    logic [CNT_W-1:0] cnt_inc;
    logic             in_fire;

    // The first product of a vector is added to zero, so IDLE and ACCUM share one datapath.
    assign add_a   = (state_reg == IDLE) ? '0 : acc_reg;
    assign add_b   = ACC_W'(sext_prod(prod_i));
    assign cnt_inc = cnt_reg + CNT_W'(1);

    mac_add_sat #(.W(ACC_W)) u_add (
        .a   (add_a),
        .b   (add_b),
        .sum (add_sum),
        .ovf (add_ovf)
    );

    // rdy_reg keeps in_ready low until the first edge after reset release.
    assign in_ready  = rdy_reg && (state_reg != HOLD);
    assign in_fire   = in_valid && in_ready;
    assign out_valid = (state_reg == HOLD);
    assign sum_o     = sum_reg;
    assign ovf_o     = ovf_reg;

    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        cnt_next   = cnt_reg;
        sum_next   = sum_reg;
        ovf_next   = ovf_reg;
        case (state_reg)
            IDLE, ACCUM: begin
                if (flush) begin
                    acc_next   = '0;
                    cnt_next   = '0;
                    ovf_next   = 1'b0;
                    state_next = IDLE;
                end else if (in_fire) begin
                    acc_next = add_sum;
                    cnt_next = cnt_inc;
                    ovf_next = ((state_reg == IDLE) ? 1'b0 : ovf_reg) | add_ovf;
                    if (cnt_inc == CNT_W'(N_TERMS)) begin
                        sum_next   = add_sum;
                        state_next = HOLD;
                    end else begin
                        state_next = ACCUM;
                    end
                end
            end
            HOLD: begin
                // flush is deliberately ignored here so a finished result is never dropped.
                if (out_ready) begin
                    acc_next   = '0;
                    cnt_next   = '0;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            sum_reg   <= '0;
            ovf_reg   <= 1'b0;
            rdy_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            cnt_reg   <= cnt_next;
            sum_reg   <= sum_next;
            ovf_reg   <= ovf_next;
            rdy_reg   <= 1'b1;
        end
    end

endmodule

// File: doc/mac_accum.md
Name: mac_accum

Overview:
- Sequential accumulator directly downstream of the 3x3 signed multiplier stage.
- Consumes a stream of 6-bit two's-complement products over a valid/ready handshake.
- Sums exactly N_TERMS products into one dot-product result, then presents it on a valid/ready output port.
- Used to measure accumulated error of exact vs approximate multipliers over vectors.

Parameters:
- N_TERMS, 8, products per accumulation; legal range 2..256.
- PROD_W, 6, product width; signed two's complement.
- ACC_W, PROD_W+$clog2(N_TERMS) (=9), accumulator and result width; may be set smaller to exercise overflow handling.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- prod_i  in  PROD_W  signed product from the multiplier.
- in_valid  in  1  prod_i is valid.
- in_ready  out  1  block accepts prod_i this cycle.
- flush  in  1  synchronous abort: discard partial sum, return to IDLE.
- sum_o  out  ACC_W  signed accumulated result.
- out_valid  out  1  sum_o is valid.
- out_ready  in  1  consumer takes sum_o.
- ovf_o  out  1  sticky flag: this result overflowed or saturated; valid with out_valid.

Behaviour:
- Reset (async, rst=1) values:
  - state=IDLE, acc=0, cnt=0.
  - sum_o=0, out_valid=0, ovf_o=0, in_ready=0.
  - in_ready goes to 1 on the first clk edge after rst deasserts.
- Transfer rules:
  - Input transfer = in_valid & in_ready at a rising clk edge.
  - Output transfer = out_valid & out_ready at a rising clk edge.
- State machine:
  - IDLE: in_ready=1. On input transfer: acc<=sext(prod_i), cnt<=1, ovf<=0, go ACCUM. If N_TERMS==1 is ever allowed, go straight to HOLD.
  - ACCUM: in_ready=1. On input transfer: acc<=acc+sext(prod_i), cnt<=cnt+1. On the transfer that makes cnt==N_TERMS: sum_o<=new acc, out_valid<=1, go HOLD. No transfer: hold state.
  - HOLD: in_ready=0. sum_o and ovf_o stay stable while out_valid=1 and out_ready=0. On output transfer: out_valid<=0, go IDLE; in_ready is 1 in the following cycle.
- No pass-through: a new vector cannot start in the same cycle the result is taken. Throughput is N_TERMS+1 cycles per result, minimum.
- Latency: out_valid rises on the clock edge that accepts the last product, i.e. 1 cycle after the last prod_i is presented.
- Arithmetic:
  - prod_i is sign-extended to ACC_W.
  - Addition is ACC_W bits, two's complement.
  - Without the optional feature, overflow wraps modulo 2^ACC_W.
  - ovf_o sets if any add of the current vector overflowed. Signed overflow is operands of equal sign giving a result of different sign.
  - Overflow is impossible at the default ACC_W.
- flush:
  - Flush in IDLE/ACCUM: acc<=0, cnt<=0, ovf<=0, state<=IDLE. Any same-cycle input transfer is dropped.
  - Flush in HOLD is ignored; a pending result is never lost.
- Bubbles: in_valid may deassert mid-vector; cnt and acc hold.
- rst asserted mid-vector or in HOLD: immediate return to reset values; the partial or pending result is lost.

Optional Feature:
- Macro MAC_ACCUM_SAT_EN.
- Defined: each add saturates to +(2^(ACC_W-1)-1) or -(2^(ACC_W-1)); ovf_o sets on any clamp. Later adds start from the clamped value.
- Undefined: wrap-around as above; ovf_o still reports wrap.

Decomposition:
- Shared package mac_pkg holds:
  - typedef enum logic [1:0] {IDLE, ACCUM, HOLD} mac_state_t.
  - localparam PROD_W=6.
  - Function sext_prod() for sign extension to ACC_W.
- One natural sub-module, mac_add_sat: combinational ACC_W adder with overflow detect. Saturation logic is inside `ifdef MAC_ACCUM_SAT_EN.
- FSM, counter and output register stay in mac_accum.

Test Plan:
- Default params; 8 back-to-back prod_i=16 (6'h10) -> out_valid 1 cycle after the 8th; sum_o=128 (9'h080); ovf_o=0.
- 8 products of -12 (6'h34) with in_valid gaps every other cycle -> sum_o=-96 (9'h1A0). in_ready stays 1 through the vector; out_valid only after the 8th accepted product.
- HOLD backpressure: out_ready=0 for 5 cycles -> sum_o and out_valid stable, in_ready=0, in_valid ignored. out_ready=1 -> in_ready=1 next cycle; the next vector sums independently.
- flush after 3 products of 5, then 8 products of 1 -> sum_o=8. flush asserted in HOLD -> result still delivered.
- ACC_W=6, 8 products of 16:
  - Without MAC_ACCUM_SAT_EN: sum_o=0, ovf_o=1.
  - With MAC_ACCUM_SAT_EN: sum_o=31, ovf_o=1.
  - 8 products of -12: sum_o=-32, ovf_o=1.
- rst asserted asynchronously mid-vector (between edges) -> outputs go to reset values immediately. After release, a fresh vector of 8 x 3 gives sum_o=24.
